fsm_serial_arb: RTL and testbench

FSM_SERIAL_ARB -- requirements
Module: fsm_serial_arb

---
 rtl/fsm_serial_arb.sv | 136 +++++++++++++
 tb/tb_fsm_serial_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fsm_serial_arb.sv
// Two-requester round-robin arbiter that serializes a word into a pattern FSM and collects its responses.
// Define FSM_ARB_FIXED_PRIO_EN to make requester 0 always win ties.
module fsm_serial_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             fsm_rst_n,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic [WIDTH-1:0] cap, cap_n;
    logic [WIDTH-1:0] result_n;
    logic             owner, owner_n;
    logic             pick;
    logic             gnt0_n, gnt1_n, ser_n, rstn_n, done_n, done_id_n;

`ifdef FSM_ARB_FIXED_PRIO_EN
    assign pick = ~req0;
`else
    logic last;

    assign pick = (req0 & req1) ? ~last : req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last <= 1'b1;
        else if (state == IDLE && (req0 | req1))
            last <= pick;
    end
`endif

    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sreg_n    = sreg;
        cap_n     = cap;
        owner_n   = owner;
        result_n  = result;
        gnt0_n    = 1'b0;
        gnt1_n    = 1'b0;
        ser_n     = 1'b0;
        rstn_n    = 1'b1;
        done_n    = 1'b0;
        done_id_n = done_id;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_n = LOAD;
                    owner_n = pick;
                    gnt0_n  = ~pick;
                    gnt1_n  = pick;
                    rstn_n  = 1'b0;
                    sreg_n  = pick ? data1 : data0;
                end
            end
            LOAD: begin
                state_n = SHIFT;
                cnt_n   = '0;
                ser_n   = sreg[0];
                sreg_n  = sreg >> 1;
            end
            SHIFT: begin
                // ser_in lags ser_out by one cycle, so cycle k returns bit k-1
                if (cnt != '0)
                    cap_n[cnt - 1'b1] = ser_in;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                end else begin
                    ser_n  = sreg[0];
                    sreg_n = sreg >> 1;
                    cnt_n  = cnt + 1'b1;
                end
            end
            DONE: begin
                state_n              = IDLE;
                result_n             = cap;
                result_n[WIDTH-1]    = ser_in;
                done_n               = 1'b1;
                done_id_n            = owner;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sreg      <= '0;
            cap       <= '0;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ser_out   <= 1'b0;
            fsm_rst_n <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            result    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            cap       <= cap_n;
            owner     <= owner_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            ser_out   <= ser_n;
            fsm_rst_n <= rstn_n;
            done      <= done_n;
            done_id   <= done_id_n;
            result    <= result_n;
        end
    end

endmodule

// File: tb/tb_fsm_serial_arb.sv
// Bench for fsm_serial_arb: a sticky "seen a one" pattern FSM on the serial side,
// cycle-position transfer model, directed cases and random request traffic.
module tb_fsm_serial_arb;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         gnt0, gnt1, ser_out, ser_in, fsm_rst_n, busy, done, done_id;
    logic [W-1:0] result;

    always #5 clk = ~clk;

    fsm_serial_arb #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1),
        .ser_out(ser_out), .ser_in(ser_in), .fsm_rst_n(fsm_rst_n),
        .busy(busy), .done(done), .done_id(done_id), .result(result)
    );

    // Pattern FSM: output 1 until a 1 has been received since its reset
    logic seen;
    always_ff @(posedge clk) begin
        if (!fsm_rst_n) seen <= 1'b0;
        else if (ser_out) seen <= 1'b1;
    end
    assign ser_in = ~seen;

    int           n_vec = 0, n_err = 0;
    int           cyc = 0, avail = 0, t0 = 0, n_rl = 0;
    bit           act = 0, own = 0, last = 1, m_id = 0;
    logic [W-1:0] dat = '0, m_res = '0;
    int           gnt_log[$], g_cyc[$], done_cyc[$];
    logic [W-1:0] done_res[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] resp(input logic [W-1:0] d);
        logic [W-1:0] r;
        bit s;
        s = 0;
        for (int k = 0; k < W; k++) begin
            s    = s | d[k];
            r[k] = !s;
        end
        return r;
    endfunction

    task automatic model_clear();
        act = 0; avail = 0; last = 1; m_res = '0; m_id = 0;
    endtask

    task automatic step(input bit rnd);
        logic eg0, eg1, eb, ef, es, ed;
        int d;
        if (!reset && cyc >= avail && (req0 || req1)) begin
`ifdef FSM_ARB_FIXED_PRIO_EN
            own = !req0;
`else
            own = (req0 && req1) ? !last : req1;
`endif
            last = own; dat = own ? data1 : data0;
            t0 = cyc; act = 1; avail = cyc + W + 3;
        end
        @(negedge clk);
        cyc++;
        eg0 = 0; eg1 = 0; eb = 0; es = 0; ed = 0; ef = !reset;
        if (act) begin
            d = cyc - t0;
            if (d == 1) begin
                ef = 0;
                if (own) eg1 = 1; else eg0 = 1;
            end
            eb = (d >= 1 && d <= W + 2);
            if (d >= 2 && d <= W + 1) es = dat[d-2];
            if (d == W + 3) begin
                ed = 1; m_res = resp(dat); m_id = own; act = 0;
            end
        end
        chk("gnt0", gnt0, eg0);
        chk("gnt1", gnt1, eg1);
        chk("busy", busy, eb);
        chk("fsm_rst_n", fsm_rst_n, ef);
        chk("ser_out", ser_out, es);
        chk("done", done, ed);
        chk("done_id", done_id, m_id);
        chk("result", result, m_res);
        if (!reset && fsm_rst_n === 1'b0) n_rl++;
        if (gnt0 === 1'b1) begin gnt_log.push_back(0); g_cyc.push_back(cyc); end
        if (gnt1 === 1'b1) begin gnt_log.push_back(1); g_cyc.push_back(cyc); end
        if (done === 1'b1) begin done_cyc.push_back(cyc); done_res.push_back(result); end
        if (rnd) begin
            if (eg0 && $urandom_range(1, 0) == 1) req0 = 0;
            if (eg1 && $urandom_range(1, 0) == 1) req1 = 0;
            if (!req0 && $urandom_range(3, 0) == 0) begin req0 = 1; data0 = W'($urandom); end
            if (!req1 && $urandom_range(3, 0) == 0) begin req1 = 1; data1 = W'($urandom); end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    int nd;

    initial begin
        model_clear();
        run(3);
        reset = 0;
        run(2);

        // single req0, all-zero word
        data0 = 8'h00; req0 = 1;
        step(0);
        req0 = 0;
        run(12);
        chk("r028_res", result, 8'hFF);
        chk("r028_id", done_id, 0);
        chk("r028_lat", done_cyc[$] - g_cyc[$], W + 2);

        // single req1, word 01
        n_rl = 0;
        data1 = 8'h01; req1 = 1;
        step(0);
        req1 = 0;
        run(12);
        chk("r029_res", result, 8'h00);
        chk("r029_id", done_id, 1);
        chk("r029_rstlow", n_rl, 1);

        // both held for three transfers
        gnt_log.delete();
        data0 = W'($urandom); data1 = W'($urandom);
        req0 = 1; req1 = 1;
        for (int i = 0; i < 60 && gnt_log.size() < 3; i++) step(0);
        req0 = 0; req1 = 0;
        run(12);
        chk("r030_cnt", gnt_log.size(), 3);
`ifdef FSM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 3; i++)
            if (i < gnt_log.size()) chk("r030_order", gnt_log[i], 0);
`else
        for (int i = 0; i < 3; i++)
            if (i < gnt_log.size()) chk("r030_order", gnt_log[i], i % 2);
`endif

        // reset during SHIFT cycle 4
        nd = done_cyc.size();
        data0 = 8'h5A; req0 = 1;
        step(0);
        req0 = 0;
        run(5);
        reset = 1;
        model_clear();
        step(0);
        chk("r031_busy", busy, 0);
        chk("r031_rstn", fsm_rst_n, 0);
        step(0);
        reset = 0;
        run(12);
        chk("r031_nodone", done_cyc.size(), nd);
        chk("r031_res", result, 0);
        data1 = 8'h00; req1 = 1;
        step(0);
        req1 = 0;
        run(12);
        chk("r031_after", result, 8'hFF);
        chk("r031_afterid", done_id, 1);

        // back-to-back transfers of the same word
        nd = done_cyc.size();
        data0 = 8'h05; req0 = 1;
        for (int i = 0; i < 40 && done_cyc.size() < nd + 2; i++) step(0);
        req0 = 0;
        run(12);
        chk("r032_cnt", done_cyc.size(), nd + 2);
        if (done_cyc.size() >= nd + 2) begin
            chk("r032_gap", done_cyc[nd+1] - done_cyc[nd], W + 3);
            chk("r032_res0", done_res[nd], resp(8'h05));
            chk("r032_res1", done_res[nd+1], resp(8'h05));
        end

        // random traffic
        for (int i = 0; i < 600; i++) step(1);
        req0 = 0; req1 = 0;
        run(14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
